pixel_mem_sched: RTL and testbench
==================================

PIXEL_MEM_SCHED -- requirements
Module: pixel_mem_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 The block SHALL expose: ld_req  in  1  pipeline pixel-load request; ld_addr  in  20  linear pixel address; ld_rd  in  7  destination register tag.
REQ-003 The block SHALL expose: st_req  in  1  output-pixel store request; st_data  in  8  pixel to store.
REQ-004 The block SHALL expose: ld_gnt  out  1  load accepted; st_gnt  out  1  store accepted; stall  out  1  a request is pending but not granted this cycle.
REQ-005 The block SHALL expose: bank_rd_en  out  1; bank_sel  out  4  bank 0..9; bank_off  out  16  in-bank offset; bank_rdata  in  8  synchronous-read data, one cycle after bank_rd_en.
REQ-006 The block SHALL expose: ld_valid  out  1; ld_data  out  32  zero-extended pixel; ld_rd_out  out  7; ld_wren  out  1  writeback enable; ld_err  out  1  address out of range.
REQ-007 The block SHALL expose: out_we  out  1; out_addr  out  16; out_wdata  out  8; out_flush  out  1  one-cycle pulse when the output buffer fills.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD, RESP and FLUSH, with one transaction in flight at a time.
REQ-009 In IDLE, a granted load SHALL assert ld_gnt combinationally, register address and tag, and move to LOAD.
REQ-010 In IDLE, a granted store SHALL assert st_gnt, out_we, out_addr=wr_cnt and out_wdata=st_data in the same cycle, then increment wr_cnt.
REQ-011 In LOAD, the block SHALL assert bank_rd_en for one cycle with registered bank_sel/bank_off, then move to RESP.
REQ-012 In RESP, ld_valid and ld_wren SHALL be high for one cycle with ld_data={24'b0,bank_rdata} and ld_rd_out=tag; state returns to IDLE. Load latency: grant at T, ld_valid at T+2.
REQ-013 Bank decode SHALL use bank = floor(addr/65000) and off = addr - bank*65000; banks 0..8 hold 65000 pixels and bank 9 holds 29392.
REQ-014 An address >= 614392 SHALL NOT assert bank_rd_en; RESP SHALL then give ld_valid=1, ld_wren=0, ld_data=0 and ld_err=1.
REQ-015 A store with wr_cnt==64999 SHALL write, wrap wr_cnt to 0, and enter FLUSH. FLUSH SHALL pulse out_flush for one cycle, grant nothing, and return to IDLE.
REQ-016 When both requests arrive together in IDLE, arbitration SHALL follow REQ-020; the loser sees stall=1 and no grant.
REQ-017 Requests arriving in LOAD, RESP or FLUSH SHALL NOT be granted; stall SHALL be asserted when any request is pending.

Reset
REQ-018 rst SHALL force IDLE, wr_cnt=0, round-robin pointer=load, and all outputs 0 (ld_data, ld_rd_out, bank_sel, bank_off, out_addr, out_wdata included).
REQ-019 Reset during LOAD or RESP SHALL abort the load without ld_valid; reset during FLUSH SHALL suppress any remaining out_flush.

Configuration
REQ-020 With PIX_MEM_RR_EN defined, contention SHALL be resolved by round-robin: the pointer flips to the other requester after each grant. Without it, loads SHALL have fixed priority over stores.

Structure
REQ-021 Package pix_mem_pkg SHALL hold BANK_DEPTH=65000, NUM_BANKS=10, LAST_BANK_DEPTH=29392, TOTAL_PIXELS=614392, OUT_DEPTH=65000 and the FSM state enum.
REQ-022 Address-to-bank/offset decoding SHALL be a combinational sub-module, pix_bank_decode, which also outputs the out-of-range flag.

Verification
REQ-023 Load at ld_addr=130005, ld_rd=5 -> bank_rd_en at T+1 with bank_sel=2, bank_off=5; ld_valid at T+2 with ld_data=bank_rdata and ld_rd_out=5.
REQ-024 Load at ld_addr=614391 -> bank_sel=9, bank_off=29391; load at ld_addr=614392 -> no bank_rd_en, ld_err=1, ld_wren=0, ld_data=0.
REQ-025 65000 consecutive stores -> out_addr runs 0..64999, out_flush pulses once in the next cycle, and the next store writes out_addr=0.
REQ-026 ld_req and st_req held high together -> with PIX_MEM_RR_EN grants alternate load, store, load...; without it every grant goes to the load and the store stalls.
REQ-027 Assert rst in the LOAD cycle -> no ld_valid, wr_cnt=0, state IDLE; the next load completes with normal T+2 latency.

Source files
------------

// File: rtl/pix_mem_pkg.sv
// Shared constants and FSM state type for the pixel memory scheduler.
// The round-robin option in the top level is selected with PIX_MEM_RR_EN.
package pix_mem_pkg;

  localparam int BANK_DEPTH      = 65000;
  localparam int NUM_BANKS       = 10;
  localparam int LAST_BANK_DEPTH = 29392;
  localparam int TOTAL_PIXELS    = 614392;
  localparam int OUT_DEPTH       = 65000;

  localparam int ADDR_W = 20;
  localparam int BANK_W = 4;
  localparam int OFF_W  = 16;
  localparam int TAG_W  = 7;
  localparam int PIX_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RESP  = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/pix_bank_decode.sv
// Combinational split of a linear pixel address into bank number and in-bank offset.
// Out-of-range addresses report bank 0 / offset 0 with the out_of_range flag set.
module pix_bank_decode
  import pix_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [BANK_W-1:0] bank,
  output logic [OFF_W-1:0]  off,
  output logic              out_of_range
);

  logic [ADDR_W-1:0] base;

  // Compare against each bank boundary instead of dividing by 65000.
  always_comb begin
    bank = '0;
    base = '0;
    for (int i = 1; i < NUM_BANKS; i++) begin
      if (addr >= ADDR_W'(i * BANK_DEPTH)) begin
        bank = BANK_W'(i);
        base = ADDR_W'(i * BANK_DEPTH);
      end
    end
    out_of_range = (addr >= ADDR_W'(TOTAL_PIXELS));
    off = OFF_W'(addr - base);
    if (out_of_range) begin
      bank = '0;
      off  = '0;
    end
  end

endmodule

// File: rtl/pixel_mem_sched.sv
// Single-transaction scheduler between pixel loads (banked source memory) and output-buffer stores.
// Define PIX_MEM_RR_EN for round-robin arbitration; otherwise loads have fixed priority.
module pixel_mem_sched
  import pix_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [TAG_W-1:0]  ld_rd,
  input  logic              st_req,
  input  logic [PIX_W-1:0]  st_data,
  output logic              ld_gnt,
  output logic              st_gnt,
  output logic              stall,
  output logic              bank_rd_en,
  output logic [BANK_W-1:0] bank_sel,
  output logic [OFF_W-1:0]  bank_off,
  input  logic [PIX_W-1:0]  bank_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic [TAG_W-1:0]  ld_rd_out,
  output logic              ld_wren,
  output logic              ld_err,
  output logic              out_we,
  output logic [OFF_W-1:0]  out_addr,
  output logic [PIX_W-1:0]  out_wdata,
  output logic              out_flush
);

  state_t            state, state_next;
  logic [OFF_W-1:0]  wr_cnt;
  logic [TAG_W-1:0]  tag_q;
  logic [BANK_W-1:0] sel_q;
  logic [OFF_W-1:0]  off_q;
  logic              err_q;
  logic [BANK_W-1:0] dec_bank;
  logic [OFF_W-1:0]  dec_off;
  logic              dec_oor;
  logic              load_first, load_win, store_win, buf_full;

  pix_bank_decode u_decode (
    .addr         (ld_addr),
    .bank         (dec_bank),
    .off          (dec_off),
    .out_of_range (dec_oor)
  );

`ifdef PIX_MEM_RR_EN
  logic rr_store;

  // Pointer names the requester that wins the next contention; it moves away from whoever was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_store <= 1'b0;
    end else if (load_win) begin
      rr_store <= 1'b1;
    end else if (store_win) begin
      rr_store <= 1'b0;
    end
  end

  assign load_first = !rr_store;
`else
  assign load_first = 1'b1;
`endif

  assign load_win  = (state == IDLE) && ld_req && (!st_req || load_first);
  assign store_win = (state == IDLE) && st_req && !load_win;
  assign buf_full  = (wr_cnt == OFF_W'(OUT_DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_win) begin
          state_next = LOAD;
        end else if (store_win && buf_full) begin
          state_next = FLUSH;
        end
      end
      LOAD:    state_next = RESP;
      RESP:    state_next = IDLE;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      tag_q  <= '0;
      sel_q  <= '0;
      off_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load_win) begin
        tag_q <= ld_rd;
        sel_q <= dec_bank;
        off_q <= dec_off;
        err_q <= dec_oor;
      end
      if (store_win) begin
        wr_cnt <= buf_full ? '0 : wr_cnt + 1'b1;
      end
    end
  end

  assign bank_sel = sel_q;
  assign bank_off = off_q;

  // Outputs are held low while reset is asserted so nothing leaks out during an abort.
  always_comb begin
    ld_gnt     = 1'b0;
    st_gnt     = 1'b0;
    bank_rd_en = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_rd_out  = '0;
    ld_wren    = 1'b0;
    ld_err     = 1'b0;
    out_we     = 1'b0;
    out_addr   = '0;
    out_wdata  = '0;
    out_flush  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          ld_gnt = load_win;
          st_gnt = store_win;
          out_we = store_win;
          if (store_win) begin
            out_addr  = wr_cnt;
            out_wdata = st_data;
          end
        end
        LOAD: bank_rd_en = !err_q;
        RESP: begin
          ld_valid  = 1'b1;
          ld_wren   = !err_q;
          ld_err    = err_q;
          ld_rd_out = tag_q;
          if (!err_q) begin
            ld_data = {24'b0, bank_rdata};
          end
        end
        FLUSH:   out_flush = 1'b1;
        default: ;
      endcase
    end
    stall = !rst && ((ld_req && !ld_gnt) || (st_req && !st_gnt));
  end

endmodule

// File: tb/tb_pixel_mem_sched.sv
// Scoreboard bench for pixel_mem_sched: a transaction-level model predicts grants and responses.
// Build with +define+PIX_MEM_RR_EN to check the round-robin variant.
module tb_pixel_mem_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req = 1'b0;
  logic [19:0] ld_addr = '0;
  logic [6:0]  ld_rd = '0;
  logic        st_req = 1'b0;
  logic [7:0]  st_data = '0;
  logic        ld_gnt, st_gnt, stall;
  logic        bank_rd_en;
  logic [3:0]  bank_sel;
  logic [15:0] bank_off;
  logic [7:0]  bank_rdata = '0;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [6:0]  ld_rd_out;
  logic        ld_wren, ld_err;
  logic        out_we;
  logic [15:0] out_addr;
  logic [7:0]  out_wdata;
  logic        out_flush;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; int sel; int off; } bank_exp_t;
  typedef struct { int cyc; logic [31:0] data; logic [6:0] rd; logic err; } resp_exp_t;
  typedef struct { int cyc; int addr; logic [7:0] data; } store_exp_t;

  bank_exp_t  bank_q[$];
  resp_exp_t  resp_q[$];
  store_exp_t store_q[$];
  int         flush_q[$];

  // Model state: cycles the block stays busy, output write count, arbitration turn.
  int busy = 0;
  int wr_m = 0;
`ifdef PIX_MEM_RR_EN
  bit rr_load = 1'b1;
`endif

  pixel_mem_sched dut (
    .clk        (clk),
    .rst        (rst),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_rd      (ld_rd),
    .st_req     (st_req),
    .st_data    (st_data),
    .ld_gnt     (ld_gnt),
    .st_gnt     (st_gnt),
    .stall      (stall),
    .bank_rd_en (bank_rd_en),
    .bank_sel   (bank_sel),
    .bank_off   (bank_off),
    .bank_rdata (bank_rdata),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_rd_out  (ld_rd_out),
    .ld_wren    (ld_wren),
    .ld_err     (ld_err),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .out_flush  (out_flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int b, input int o);
    return 8'((b * 71) ^ (o * 13) ^ (o >> 8));
  endfunction

  // Synchronous-read pixel banks; non-read cycles return a junk pattern.
  always @(posedge clk) begin
    bank_rdata <= bank_rd_en ? pix(int'(bank_sel), int'(bank_off)) : 8'hA5;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic clearModel();
    bank_q.delete();
    resp_q.delete();
    store_q.delete();
    flush_q.delete();
    busy = 0;
    wr_m = 0;
`ifdef PIX_MEM_RR_EN
    rr_load = 1'b1;
`endif
  endtask

  task automatic applyStimulus(input logic l, input logic [19:0] a, input logic [6:0] r,
                               input logic s, input logic [7:0] d);
    bit         win_l, win_s, lf, err;
    bank_exp_t  be;
    resp_exp_t  re;
    store_exp_t se;
    @(posedge clk);
    #1;
    ld_req = l; ld_addr = a; ld_rd = r; st_req = s; st_data = d;
    win_l = 1'b0;
    win_s = 1'b0;
    if (busy > 0) begin
      busy--;
    end else begin
`ifdef PIX_MEM_RR_EN
      lf = rr_load;
`else
      lf = 1'b1;
`endif
      win_l = l && (!s || lf);
      win_s = s && !win_l;
      if (win_l) begin
        err = (int'(a) >= 614392);
        if (!err) begin
          be.cyc = cyc + 1; be.sel = int'(a) / 65000; be.off = int'(a) % 65000;
          bank_q.push_back(be);
        end
        re.cyc = cyc + 2;
        re.data = err ? 32'd0 : {24'd0, pix(int'(a) / 65000, int'(a) % 65000)};
        re.rd = r;
        re.err = err;
        resp_q.push_back(re);
        busy = 2;
`ifdef PIX_MEM_RR_EN
        rr_load = 1'b0;
`endif
      end else if (win_s) begin
        se.cyc = cyc; se.addr = wr_m; se.data = d;
        store_q.push_back(se);
        if (wr_m == 64999) begin
          wr_m = 0;
          flush_q.push_back(cyc + 1);
          busy = 1;
        end else begin
          wr_m++;
        end
`ifdef PIX_MEM_RR_EN
        rr_load = 1'b1;
`endif
      end
    end
    #1;
    checkOutput("ld_gnt", 32'(ld_gnt), 32'(win_l));
    checkOutput("st_gnt", 32'(st_gnt), 32'(win_s));
    checkOutput("stall", 32'(stall), 32'((l && !win_l) || (s && !win_s)));
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ld_req = 1'b0;
    st_req = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("rst_ctrl", 32'({ld_gnt, st_gnt, stall, bank_rd_en, ld_valid, ld_wren, ld_err, out_we, out_flush}), 32'd0);
    checkOutput("rst_bank", 32'({bank_sel, bank_off}), 32'd0);
    checkOutput("rst_ld_data", ld_data, 32'd0);
    checkOutput("rst_ld_rd", 32'(ld_rd_out), 32'd0);
    checkOutput("rst_out", 32'({out_addr, out_wdata}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops expectations whose due cycle has arrived and flags any unexpected output.
  initial begin
    bank_exp_t  b;
    resp_exp_t  rsp;
    store_exp_t st;
    forever begin
      @(negedge clk);
      if (bank_q.size() > 0 && bank_q[0].cyc == cyc) begin
        b = bank_q.pop_front();
        checkOutput("bank_rd_en", 32'(bank_rd_en), 32'd1);
        checkOutput("bank_sel", 32'(bank_sel), b.sel);
        checkOutput("bank_off", 32'(bank_off), b.off);
      end else if (bank_rd_en !== 1'b0) begin
        checkOutput("bank_rd_unexpected", 32'(bank_rd_en), 32'd0);
      end
      if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
        rsp = resp_q.pop_front();
        checkOutput("ld_valid", 32'(ld_valid), 32'd1);
        checkOutput("ld_data", ld_data, rsp.data);
        checkOutput("ld_rd_out", 32'(ld_rd_out), 32'(rsp.rd));
        checkOutput("ld_wren", 32'(ld_wren), 32'(!rsp.err));
        checkOutput("ld_err", 32'(ld_err), 32'(rsp.err));
      end else if (ld_valid !== 1'b0) begin
        checkOutput("ld_valid_unexpected", 32'(ld_valid), 32'd0);
      end
      if (store_q.size() > 0 && store_q[0].cyc == cyc) begin
        st = store_q.pop_front();
        checkOutput("out_we", 32'(out_we), 32'd1);
        checkOutput("out_addr", 32'(out_addr), st.addr);
        checkOutput("out_wdata", 32'(out_wdata), 32'(st.data));
      end else if (out_we !== 1'b0) begin
        checkOutput("out_we_unexpected", 32'(out_we), 32'd0);
      end
      if (flush_q.size() > 0 && flush_q[0] == cyc) begin
        void'(flush_q.pop_front());
        checkOutput("out_flush", 32'(out_flush), 32'd1);
      end else if (out_flush !== 1'b0) begin
        checkOutput("out_flush_unexpected", 32'(out_flush), 32'd0);
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dir_addr[9];
    dir_addr = '{130005, 0, 64999, 65000, 584999, 585000, 614391, 614392, 1048575};

    resetPulse();

    // Boundary loads around bank edges and the end of the pixel space.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 20'(dir_addr[i]), 7'(i + 5), 1'b0, 8'h00);
      applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
      applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    end

    // Both requesters held high together.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 20'($urandom_range(0, 614391)), 7'($urandom_range(0, 127)),
                    1'b1, 8'($urandom_range(0, 255)));
    end
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);

    // Reset while a load sits in LOAD, then confirm counters and latency start clean.
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b1, 8'h11);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b1, 8'h22);
    applyStimulus(1'b1, 20'd200000, 7'd33, 1'b0, 8'h00);
    resetPulse();
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b1, 8'h33);
    applyStimulus(1'b1, 20'd300001, 7'd44, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);

    // Random traffic, roughly one load in eight out of range.
    for (int i = 0; i < 1500; i++) begin
      logic [19:0] a;
      a = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(614392, 1048575))
                                      : 20'($urandom_range(0, 614391));
      applyStimulus(1'($urandom_range(0, 2) == 0), a, 7'($urandom_range(0, 127)),
                    1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
    end
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);

    // Fill the output buffer from empty, through the flush, and one store past the wrap.
    resetPulse();
    for (int i = 0; i < 65002; i++) begin
      applyStimulus(1'b0, 20'd0, 7'd0, 1'b1, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 20'd0, 7'd0, 1'b0, 8'h00);
    end

    checkOutput("bank_q_drained", 32'(bank_q.size()), 32'd0);
    checkOutput("resp_q_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("store_q_drained", 32'(store_q.size()), 32'd0);
    checkOutput("flush_q_drained", 32'(flush_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
